// File: rtl/calc_pkg.sv
// Shared constants for the calculator core: operator codes, FSM state encodings, flag bit positions.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [2:0] {
        S_A    = 3'b000,
        S_OP   = 3'b001,
        S_B    = 3'b010,
        S_EXEC = 3'b011,
        S_RES  = 3'b100
    } state_t;

    localparam int unsigned FLAG_W = 4;

    localparam logic [1:0] F_N = 2'd3;
    localparam logic [1:0] F_Z = 2'd2;
    localparam logic [1:0] F_V = 2'd1;
    localparam logic [1:0] F_C = 2'd0;

endpackage

// File: rtl/calc_alu.sv
// Combinational W-bit ALU: add/sub with carry/borrow and overflow (optionally saturating), bitwise and/or.
module calc_alu
    import calc_pkg::*;
#(
    parameter int unsigned W        = 8,
    parameter bit          SATURATE = 1'b0
) (
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    input  logic [1:0]        op,
    output logic [W-1:0]      y,
    output logic [FLAG_W-1:0] flags
);

    logic [W:0] sum;
    logic [W:0] diff;
    logic       v_add;
    logic       v_sub;

    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        v_add = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
        v_sub = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
        y     = '0;
        flags = '0;
        case (op)
            OP_ADD: begin
                y          = sum[W-1:0];
                flags[F_C] = sum[W];
                flags[F_V] = v_add;
            end
            OP_SUB: begin
                y          = diff[W-1:0];
                flags[F_C] = diff[W];
                flags[F_V] = v_sub;
            end
            OP_AND:  y = a & b;
            default: y = a | b;
        endcase
        // Overflow direction always follows the sign of a for both add and sub
        if (SATURATE && flags[F_V]) begin
            y = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        flags[F_N] = y[W-1];
        flags[F_Z] = (y == '0);
    end

endmodule

// File: rtl/calc_core.sv
// Calculator control and datapath: operand/operator/result FSM, chaining, repeat-equals, display mux.
module calc_core
    import calc_pkg::*;
#(
    parameter int unsigned W        = 8,
    parameter bit          SATURATE = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [W-1:0]      operand_in,
    input  logic              entry_valid,
    input  logic              op_valid,
    input  logic [1:0]        op_code,
    input  logic              equals,
    input  logic              clear_entry,
    input  logic              clear_all,
    output logic              entry_clr,
    output logic [W-1:0]      result,
    output logic [FLAG_W-1:0] flags,
    output logic              res_valid,
    output logic [W-1:0]      disp_value,
    output logic              disp_is_result,
    output logic [2:0]        state_dbg
);

    state_t             state;
    state_t             next_state;
    logic [W-1:0]       reg_a, reg_b, reg_a_d, reg_b_d, result_d, alu_y;
    logic [1:0]         op, next_op, op_d, next_op_d;
    logic               chain, chain_d;
    logic [FLAG_W-1:0]  flags_d, alu_flags;
    logic               entry_clr_d, res_valid_d, disp_is_result_d;
    logic               do_ce, do_eq, do_op, do_ent;

    calc_alu #(.W(W), .SATURATE(SATURATE)) u_alu (
        .a     (reg_a),
        .b     (reg_b),
        .op    (op),
        .y     (alu_y),
        .flags (alu_flags)
    );

    // Only the highest-priority strobe acts; clear_all is handled directly
    always_comb begin
        do_ce  = clear_entry & ~clear_all;
        do_eq  = equals & ~clear_entry & ~clear_all;
        do_op  = op_valid & ~equals & ~clear_entry & ~clear_all;
        do_ent = entry_valid & ~op_valid & ~equals & ~clear_entry & ~clear_all;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_A;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (clear_all) begin
            next_state = S_A;
        end else begin
            case (state)
                S_A:    if (do_op) next_state = S_OP;
                S_OP:   if (do_ent) next_state = S_B;
                S_B: begin
                    if (do_eq || do_op) next_state = S_EXEC;
                    else if (do_ce)     next_state = S_OP;
                end
                S_EXEC: next_state = chain ? S_OP : S_RES;
                S_RES: begin
                    if (do_op)                next_state = S_OP;
                    else if (do_eq)           next_state = S_EXEC;
                    else if (do_ent || do_ce) next_state = S_A;
                end
                default: next_state = S_A;
            endcase
        end
    end

    always_comb begin
        reg_a_d          = reg_a;
        reg_b_d          = reg_b;
        op_d             = op;
        next_op_d        = next_op;
        chain_d          = chain;
        result_d         = result;
        flags_d          = flags;
        entry_clr_d      = 1'b0;
        res_valid_d      = 1'b0;
        disp_is_result_d = (next_state == S_RES);
        if (clear_all) begin
            reg_a_d     = '0;
            reg_b_d     = '0;
            op_d        = OP_ADD;
            next_op_d   = OP_ADD;
            chain_d     = 1'b0;
            result_d    = '0;
            flags_d     = '0;
            entry_clr_d = 1'b1;
        end else begin
            case (state)
                S_A: begin
                    if (do_op) begin
                        reg_a_d     = operand_in;
                        op_d        = op_code;
                        entry_clr_d = 1'b1;
                    end else if (do_ce) begin
                        entry_clr_d = 1'b1;
                    end
                end
                S_OP: begin
                    if (do_op)      op_d        = op_code;
                    else if (do_ce) entry_clr_d = 1'b1;
                end
                S_B: begin
                    if (do_eq) begin
                        reg_b_d = operand_in;
                        chain_d = 1'b0;
                    end else if (do_op) begin
                        reg_b_d   = operand_in;
                        next_op_d = op_code;
                        chain_d   = 1'b1;
                    end else if (do_ce) begin
                        entry_clr_d = 1'b1;
                    end
                end
                S_EXEC: begin
                    result_d = alu_y;
                    flags_d  = alu_flags;
                    // A chained operator feeds the result straight back as the next A
                    if (chain) begin
                        reg_a_d     = alu_y;
                        op_d        = next_op;
                        entry_clr_d = 1'b1;
                    end else begin
                        res_valid_d = 1'b1;
                    end
                end
                S_RES: begin
                    if (do_op) begin
                        reg_a_d     = result;
                        op_d        = op_code;
                        entry_clr_d = 1'b1;
                    end else if (do_eq) begin
                        reg_a_d = result;
                    end else if (do_ce) begin
                        entry_clr_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            reg_a          <= '0;
            reg_b          <= '0;
            op             <= OP_ADD;
            next_op        <= OP_ADD;
            chain          <= 1'b0;
            result         <= '0;
            flags          <= '0;
            entry_clr      <= 1'b0;
            res_valid      <= 1'b0;
            disp_is_result <= 1'b0;
        end else begin
            reg_a          <= reg_a_d;
            reg_b          <= reg_b_d;
            op             <= op_d;
            next_op        <= next_op_d;
            chain          <= chain_d;
            result         <= result_d;
            flags          <= flags_d;
            entry_clr      <= entry_clr_d;
            res_valid      <= res_valid_d;
            disp_is_result <= disp_is_result_d;
        end
    end

    assign disp_value = disp_is_result ? result : operand_in;
    assign state_dbg  = state;

endmodule

// File: tb/tb_calc_core.sv
// Self-checking bench for calc_core (W=8): wrapping and saturating instances driven in parallel.
module tb_calc_core;

    typedef struct {
        logic [7:0] r0;
        logic [3:0] f0;
        logic [7:0] r1;
        logic [3:0] f1;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] operand_in;
    logic       entry_valid, op_valid, equals, clear_entry, clear_all;
    logic [1:0] op_code;

    logic       entry_clr0, res_valid0, disp_is_result0;
    logic [7:0] result0, disp_value0;
    logic [3:0] flags0;
    logic [2:0] state_dbg0;
    logic       entry_clr1, res_valid1, disp_is_result1;
    logic [7:0] result1, disp_value1;
    logic [3:0] flags1;
    logic [2:0] state_dbg1;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    calc_core #(.W(8), .SATURATE(1'b0)) u_wrap (
        .clock(clk), .reset(rst_n), .operand_in(operand_in), .entry_valid(entry_valid),
        .op_valid(op_valid), .op_code(op_code), .equals(equals), .clear_entry(clear_entry),
        .clear_all(clear_all), .entry_clr(entry_clr0), .result(result0), .flags(flags0),
        .res_valid(res_valid0), .disp_value(disp_value0), .disp_is_result(disp_is_result0),
        .state_dbg(state_dbg0)
    );

    calc_core #(.W(8), .SATURATE(1'b1)) u_sat (
        .clock(clk), .reset(rst_n), .operand_in(operand_in), .entry_valid(entry_valid),
        .op_valid(op_valid), .op_code(op_code), .equals(equals), .clear_entry(clear_entry),
        .clear_all(clear_all), .entry_clr(entry_clr1), .result(result1), .flags(flags1),
        .res_valid(res_valid1), .disp_value(disp_value1), .disp_is_result(disp_is_result1),
        .state_dbg(state_dbg1)
    );

    // Reference arithmetic in plain integers: index 0 wraps, index 1 saturates
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        exp_t       e;
        int         s;
        bit         v, c;
        logic [7:0] w, t;
        v = 1'b0;
        c = 1'b0;
        s = 0;
        if (op == 2'b00) begin
            s = int'($signed(a)) + int'($signed(b));
            c = (int'(a) + int'(b)) > 255;
        end else if (op == 2'b01) begin
            s = int'($signed(a)) - int'($signed(b));
            c = int'(a) < int'(b);
        end
        if (op[1]) begin
            w = (op == 2'b10) ? (a & b) : (a | b);
            t = w;
        end else begin
            v = (s > 127) || (s < -128);
            w = 8'(s);
            t = !v ? w : ((s > 127) ? 8'h7F : 8'h80);
        end
        e.r0 = w;
        e.f0 = {w[7], w == 8'h00, v, c};
        e.r1 = t;
        e.f1 = {t[7], t == 8'h00, v, c};
        return e;
    endfunction

    // Key-press tasks: start on a falling edge, hold the strobe over one rising edge
    task automatic key_digit(input logic [7:0] v);
        operand_in = v; entry_valid = 1'b1;
        @(negedge clk); entry_valid = 1'b0;
    endtask

    task automatic key_op(input logic [7:0] v, input logic [1:0] code);
        operand_in = v; op_valid = 1'b1; op_code = code;
        @(negedge clk); op_valid = 1'b0;
    endtask

    task automatic key_eq(input logic [7:0] v);
        operand_in = v; equals = 1'b1;
        @(negedge clk); equals = 1'b0;
    endtask

    task automatic wait_res(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (res_valid0) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        operand_in = 8'h5A; #1;
        checks++; if (state_dbg0 !== 3'b000) begin failures++; $display("FAIL rst_state got=%0h exp=0", state_dbg0); end
        checks++; if ({result0, flags0} !== 12'h000) begin failures++; $display("FAIL rst_result got=%0h/%0h exp=0/0", result0, flags0); end
        checks++; if (disp_value0 !== 8'h5A || disp_is_result0 !== 1'b0) begin failures++; $display("FAIL rst_disp got=%0h/%0b exp=5a/0", disp_value0, disp_is_result0); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        // Start 3+4 and pull reset while the core sits in S_EXEC
        key_digit(8'd3); key_op(8'd3, 2'b00); key_digit(8'd4); key_eq(8'd4);
        e = model(8'd3, 8'd4, 2'b00);
        checks++; if (state_dbg0 !== 3'b011) begin failures++; $display("FAIL rst_pre_exec got=%0h exp=3", state_dbg0); end
        rst_n = 1'b0;
        @(negedge clk);
        operand_in = 8'h33; #1;
        checks++; if (state_dbg0 !== 3'b000 || result0 !== 8'h00 || result0 === e.r0) begin failures++; $display("FAIL rst_mid_exec got=%0h/%0h exp=0/0", state_dbg0, result0); end
        checks++; if (flags0 !== 4'b0000 || res_valid0 !== 1'b0 || entry_clr0 !== 1'b0) begin failures++; $display("FAIL rst_mid_flags got=%0b/%0b/%0b exp=0000/0/0", flags0, res_valid0, entry_clr0); end
        checks++; if (disp_value0 !== 8'h33 || disp_is_result0 !== 1'b0) begin failures++; $display("FAIL rst_mid_disp got=%0h/%0b exp=33/0", disp_value0, disp_is_result0); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        exp_t e;
        key_digit(8'd25);
        key_op(8'd25, 2'b00);
        checks++; if (state_dbg0 !== 3'b001 || entry_clr0 !== 1'b1) begin failures++; $display("FAIL basic_op got=%0h/%0b exp=1/1", state_dbg0, entry_clr0); end
        key_digit(8'd17);
        key_eq(8'd17);
        sb.push_back(model(8'd25, 8'd17, 2'b00));
        checks++; if (state_dbg0 !== 3'b011 || res_valid0 !== 1'b0) begin failures++; $display("FAIL basic_exec got=%0h/%0b exp=3/0", state_dbg0, res_valid0); end
        @(negedge clk);
        e = sb.pop_front();
        checks++; if (state_dbg0 !== 3'b100 || res_valid0 !== 1'b1) begin failures++; $display("FAIL basic_res got=%0h/%0b exp=4/1", state_dbg0, res_valid0); end
        checks++; if (result0 !== e.r0 || flags0 !== e.f0 || result1 !== e.r1) begin failures++; $display("FAIL basic_value got=%0h/%0b exp=%0h/%0b", result0, flags0, e.r0, e.f0); end
        checks++; if (disp_is_result0 !== 1'b1 || disp_value0 !== e.r0) begin failures++; $display("FAIL basic_disp got=%0b/%0h exp=1/%0h", disp_is_result0, disp_value0, e.r0); end
        @(negedge clk);
        checks++; if (res_valid0 !== 1'b0 || result0 !== e.r0) begin failures++; $display("FAIL basic_pulse got=%0b/%0h exp=0/%0h", res_valid0, result0, e.r0); end
    endtask

    task automatic test_arith();
        logic [7:0] ta [7] = '{8'd100, 8'd0, 8'h80, 8'h7F, 8'd5, 8'hA5, 8'h0C};
        logic [7:0] tb [7] = '{8'd100, 8'd1, 8'd1, 8'd1, 8'd5, 8'h0F, 8'h30};
        logic [1:0] to [7] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b10, 2'b11};
        exp_t e;
        bit   tmo;
        for (int i = 0; i < 7; i++) begin
            key_digit(ta[i]); key_op(ta[i], to[i]); key_digit(tb[i]); key_eq(tb[i]);
            sb.push_back(model(ta[i], tb[i], to[i]));
            wait_res(tmo);
            checks++;
            if (tmo) begin
                failures++; $display("FAIL arith_timeout case=%0d", i);
            end else begin
                e = sb.pop_front();
                if (result0 !== e.r0 || flags0 !== e.f0) begin failures++; $display("FAIL arith_wrap case=%0d got=%0h/%0b exp=%0h/%0b", i, result0, flags0, e.r0, e.f0); end
                checks++;
                if (result1 !== e.r1 || flags1 !== e.f1 || res_valid1 !== 1'b1) begin failures++; $display("FAIL arith_sat case=%0d got=%0h/%0b exp=%0h/%0b", i, result1, flags1, e.r1, e.f1); end
            end
        end
    endtask

    task automatic test_chain();
        exp_t e;
        bit   tmo;
        key_digit(8'd10); key_op(8'd10, 2'b01); key_digit(8'd3);
        key_op(8'd3, 2'b00);
        sb.push_back(model(8'd10, 8'd3, 2'b01));
        @(negedge clk);
        e = sb.pop_front();
        checks++; if (state_dbg0 !== 3'b001 || entry_clr0 !== 1'b1 || res_valid0 !== 1'b0) begin failures++; $display("FAIL chain_mid got=%0h/%0b/%0b exp=1/1/0", state_dbg0, entry_clr0, res_valid0); end
        checks++; if (result0 !== e.r0 || flags0 !== e.f0) begin failures++; $display("FAIL chain_inter got=%0h/%0b exp=%0h/%0b", result0, flags0, e.r0, e.f0); end
        key_digit(8'd5); key_eq(8'd5);
        sb.push_back(model(e.r0, 8'd5, 2'b00));
        wait_res(tmo);
        checks++;
        if (tmo) begin
            failures++; $display("FAIL chain_timeout");
        end else begin
            e = sb.pop_front();
            if (result0 !== e.r0 || flags0 !== e.f0) begin failures++; $display("FAIL chain_final got=%0h/%0b exp=%0h/%0b", result0, flags0, e.r0, e.f0); end
        end
    endtask

    task automatic test_repeat();
        exp_t e;
        bit   tmo;
        key_digit(8'd5); key_op(8'd5, 2'b00); key_digit(8'd2); key_eq(8'd2);
        sb.push_back(model(8'd5, 8'd2, 2'b00));
        for (int i = 0; i < 3; i++) begin
            wait_res(tmo);
            checks++;
            if (tmo) begin
                failures++; $display("FAIL repeat_timeout step=%0d", i);
                break;
            end
            e = sb.pop_front();
            if (result0 !== e.r0 || flags0 !== e.f0) begin failures++; $display("FAIL repeat_value step=%0d got=%0h exp=%0h", i, result0, e.r0); end
            @(negedge clk);
            checks++; if (res_valid0 !== 1'b0 || state_dbg0 !== 3'b100) begin failures++; $display("FAIL repeat_pulse step=%0d got=%0b/%0h exp=0/4", i, res_valid0, state_dbg0); end
            if (i < 2) begin
                // operand_in is deliberately unrelated: repeat-equals must reuse the held B
                key_eq(8'hEE);
                sb.push_back(model(e.r0, 8'd2, 2'b00));
            end
        end
    endtask

    task automatic test_clear();
        exp_t e;
        bit   tmo;
        bit   seen;
        key_digit(8'd9); key_op(8'd9, 2'b01); key_digit(8'd4);
        operand_in = 8'd4; clear_all = 1'b1; equals = 1'b1;
        @(negedge clk); clear_all = 1'b0; equals = 1'b0;
        checks++; if (state_dbg0 !== 3'b000 || result0 !== 8'h00 || flags0 !== 4'b0000) begin failures++; $display("FAIL clr_all got=%0h/%0h/%0b exp=0/0/0000", state_dbg0, result0, flags0); end
        checks++; if (entry_clr0 !== 1'b1 || disp_is_result0 !== 1'b0) begin failures++; $display("FAIL clr_all_pulse got=%0b/%0b exp=1/0", entry_clr0, disp_is_result0); end
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (res_valid0 !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen || result0 !== 8'h00) begin failures++; $display("FAIL clr_all_noexec got=%0b/%0h exp=0/0", seen, result0); end
        // equals outranks op_valid and is ignored in S_A
        operand_in = 8'd9; equals = 1'b1; op_valid = 1'b1; op_code = 2'b01;
        @(negedge clk); equals = 1'b0; op_valid = 1'b0;
        checks++; if (state_dbg0 !== 3'b000 || entry_clr0 !== 1'b0) begin failures++; $display("FAIL prio_eq_op got=%0h/%0b exp=0/0", state_dbg0, entry_clr0); end
        key_op(8'd9, 2'b01); key_digit(8'd4);
        clear_entry = 1'b1;
        @(negedge clk); clear_entry = 1'b0;
        checks++; if (state_dbg0 !== 3'b001 || entry_clr0 !== 1'b1) begin failures++; $display("FAIL clr_entry got=%0h/%0b exp=1/1", state_dbg0, entry_clr0); end
        key_digit(8'd2); key_eq(8'd2);
        sb.push_back(model(8'd9, 8'd2, 2'b01));
        wait_res(tmo);
        checks++;
        if (tmo) begin
            failures++; $display("FAIL clr_entry_timeout");
        end else begin
            e = sb.pop_front();
            if (result0 !== e.r0 || flags0 !== e.f0) begin failures++; $display("FAIL clr_entry_opkept got=%0h exp=%0h", result0, e.r0); end
        end
    endtask

    initial begin
        rst_n = 1'b0; operand_in = 8'h00; op_code = 2'b00;
        entry_valid = 1'b0; op_valid = 1'b0; equals = 1'b0; clear_entry = 1'b0; clear_all = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_arith();
        test_chain();
        test_repeat();
        test_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/calc_core.md
Name: calc_core

Overview:
- Parametrised W-bit calculator control-and-datapath core; successor to the fixed 8-bit add/subtract calculator top level.
- Sits between the keypad entry unit and the display unit.
  - Takes already-assembled two's-complement operands plus key strobes.
  - Runs an operand/operator/result state machine.
  - Drives the value to display and the flag LEDs.
- New capability: four operations, chained operators, repeat-equals, and optional saturating arithmetic.

Parameters:
W, 8, operand/result width in bits (W >= 4)
SATURATE, 0, 1 = ADD/SUB overflow clamps to most positive/most negative value; 0 = wrap

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; clears all state
operand_in  in  W  live two's-complement entry from the keypad unit
entry_valid  in  1  one-cycle pulse: a digit was entered, operand_in updated
op_valid  in  1  one-cycle pulse: operator key pressed
op_code  in  2  00 ADD, 01 SUB, 10 AND, 11 OR; sampled with op_valid
equals  in  1  one-cycle pulse: '=' key
clear_entry  in  1  one-cycle pulse: discard the current entry
clear_all  in  1  one-cycle pulse: synchronous soft clear, same effect as reset
entry_clr  out  1  one-cycle pulse to the keypad unit: restart number entry
result  out  W  registered result
flags  out  4  {N,Z,V,C} of the last executed operation
res_valid  out  1  one-cycle pulse on the first S_RES cycle
disp_value  out  W  result when disp_is_result=1, else operand_in
disp_is_result  out  1  high in S_RES only
state_dbg  out  3  current state encoding

Behaviour:
- Reset (async low) or clear_all:
  - state=S_A; reg_a, reg_b, result, flags, op, next_op, chain = 0.
  - entry_clr, res_valid = 0; disp_is_result=0.
  - clear_all additionally pulses entry_clr.
- Strobe priority when several strobes are high in one cycle: clear_all > clear_entry > equals > op_valid > entry_valid. Only the highest-priority strobe acts.
- States: S_A=000, S_OP=001, S_B=010, S_EXEC=011, S_RES=100. Encodings 101-111 go to S_A on the next clock.
- S_A (entering A):
  - op_valid: reg_a<=operand_in; op<=op_code; pulse entry_clr; go to S_OP.
  - clear_entry: pulse entry_clr; stay.
  - equals: ignored.
- S_OP (operator held, waiting for B):
  - op_valid: op<=op_code (replaces the operator); stay.
  - entry_valid: go to S_B.
  - clear_entry: pulse entry_clr; stay.
  - equals: ignored.
- S_B (entering B):
  - equals: reg_b<=operand_in; chain<=0; go to S_EXEC.
  - op_valid: reg_b<=operand_in; next_op<=op_code; chain<=1; go to S_EXEC.
  - clear_entry: pulse entry_clr; go to S_OP.
- S_EXEC (exactly one cycle):
  - result<=f(reg_a, op, reg_b); flags updated.
  - If chain=1: reg_a<=new result; op<=next_op; pulse entry_clr; go to S_OP.
  - If chain=0: go to S_RES.
- S_RES:
  - op_valid: reg_a<=result; op<=op_code; pulse entry_clr; go to S_OP.
  - equals (repeat): reg_a<=result; reg_b and op are kept; go to S_EXEC.
  - entry_valid: go to S_A (the digit starts a new A).
  - clear_entry: pulse entry_clr; go to S_A.
- Latency: equals sampled at edge k; result and flags valid after edge k+1; res_valid high during cycle k+1..k+2.
- Arithmetic:
  - Sum/difference computed at W+1 bits.
  - ADD: C = carry-out.
  - SUB: a - b; C = borrow (unsigned a < b).
  - V = signed overflow.
  - SATURATE=1 and V=1: result clamps to 2^(W-1)-1 (positive overflow) or -2^(W-1) (negative overflow). V stays 1.
  - AND/OR: bitwise; C=V=0.
  - N = result[W-1]; Z = (result==0), evaluated after saturation.
- Reset asserted mid-S_EXEC: result is not updated; everything returns to reset values.

Decomposition:
- Package calc_pkg holds:
  - op-code constants (OP_ADD, OP_SUB, OP_AND, OP_OR);
  - state encodings;
  - flag bit indices (F_N=3, F_Z=2, F_V=1, F_C=0).
- One combinational sub-module, calc_alu (params W, SATURATE): inputs a, b, op; outputs y, flags. The FSM and registers live in calc_core.

Test Plan (W=8):
1. Assert reset low mid-run -> state_dbg=000, result=0, flags=0000, disp_value tracks operand_in, disp_is_result=0.
2. A=25, ADD, B=17, equals -> S_EXEC then S_RES; result=42; flags=0000; res_valid one cycle, two edges after equals.
3. 100 ADD 100 =:
   - SATURATE=0 -> result=0xC8, flags N=1 V=1 Z=0 C=0.
   - SATURATE=1 -> result=0x7F, V=1.
   - 0 SUB 1 = -> result=0xFF, C=1 N=1.
4. Chain: 10 SUB 3, then ADD pressed -> intermediate result=7 and an entry_clr pulse; then 5, equals -> result=12.
5. Repeat-equals: 5 ADD 2 = = = -> results 7, 9, 11, each with its own res_valid pulse.
6. Simultaneous events and soft clear:
   - clear_all and equals in the same cycle while in S_B -> S_A, no result update.
   - clear_entry in S_B -> S_OP; op is kept; entry_clr pulses.
